// File: rtl/counter_dir_sweep_ctrl_if.sv
// Control/status bundle between the sweep sequencer and its driver/counter side.
// The slave modport is the sequencer's view; master is the stimulus/counter view.
interface counter_dir_sweep_ctrl_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 4,
  parameter int unsigned LW = 4
);
  logic          start;
  logic          pause;
  logic          abort;
  logic [N-1:0]  limit;
  logic [DW-1:0] dwell;
  logic [LW-1:0] loops;
  logic [N-1:0]  q;
  logic          ce;
  logic          dir;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  modport slave (
    input  start, pause, abort, limit, dwell, loops, q,
    output ce, dir, busy, done, state
  );

  modport master (
    output start, pause, abort, limit, dwell, loops, q,
    input  ce, dir, busy, done, state
  );
endinterface

// File: rtl/counter_dir_sweep_ctrl.sv
// Sweep sequencer for an up/down counter: home to 0, sweep 0->limit, dwell, sweep back,
// repeated for a latched loop count, with pause and abort.
module counter_dir_sweep_ctrl #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 4,
  parameter int unsigned LW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_dir_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHome  = 3'd1,
    StUp    = 3'd2,
    StDwell = 3'd3,
    StDown  = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          ce_q, ce_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  limit_q, limit_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [LW-1:0] loops_q, loops_d;
  logic [LW-1:0] loop_cnt_q, loop_cnt_d;
  logic [LW-1:0] loops_eff;
  logic [LW:0]   loop_next;
  logic          step;

  assign loops_eff = (loops_q == '0) ? LW'(1) : loops_q;
  assign loop_next = {1'b0, loop_cnt_q} + (LW + 1)'(1);
  // The counter moved on this edge only if ce was already high before it.
  assign step      = ce_q;

  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    dwell_d     = dwell_q;
    loops_d     = loops_q;
    dwell_cnt_d = dwell_cnt_q;
    loop_cnt_d  = loop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.limit != '0) begin
            limit_d    = bus.limit;
            dwell_d    = bus.dwell;
            loops_d    = bus.loops;
            loop_cnt_d = '0;
            state_d    = (bus.q != '0) ? StHome : StUp;
          end else begin
            state_d = StDone;
          end
        end
      end
      StHome: begin
        if (step && bus.q == N'(1)) state_d = StUp;
      end
      StUp: begin
        if (bus.q > limit_q) begin
          state_d = StDown;
        end else if (step && bus.q == limit_q - N'(1)) begin
          if (dwell_q == '0) begin
            state_d = StDown;
          end else begin
            state_d     = StDwell;
            dwell_cnt_d = dwell_q;
          end
        end
      end
      StDwell: begin
        if (!bus.pause) begin
          dwell_cnt_d = dwell_cnt_q - DW'(1);
          if (dwell_cnt_q == DW'(1)) state_d = StDown;
        end
      end
      StDown: begin
        if (step && bus.q == N'(1)) begin
          if (loop_next >= {1'b0, loops_eff}) begin
            state_d = StDone;
          end else begin
            loop_cnt_d = loop_cnt_q + LW'(1);
            state_d    = StUp;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (bus.abort && state_q != StIdle && state_q != StDone) state_d = StIdle;

    ce_d  = (state_d inside {StHome, StUp, StDown}) && !bus.pause;
    dir_d = (state_d == StUp);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ce_q        <= 1'b0;
      dir_q       <= 1'b0;
      limit_q     <= '0;
      dwell_q     <= '0;
      loops_q     <= '0;
      dwell_cnt_q <= '0;
      loop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      dir_q       <= dir_d;
      limit_q     <= limit_d;
      dwell_q     <= dwell_d;
      loops_q     <= loops_d;
      dwell_cnt_q <= dwell_cnt_d;
      loop_cnt_q  <= loop_cnt_d;
    end
  end

  assign bus.ce    = ce_q;
  assign bus.dir   = dir_q;
  assign bus.busy  = (state_q != StIdle) && (state_q != StDone);
  assign bus.done  = (state_q == StDone);
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_dir_sweep_ctrl.sv
// Bench for counter_dir_sweep_ctrl: a behavioural counter plus a work-unit queue model
// (home/up/dwell/down units consumed one per cycle, delayed by pause).
module tb_counter_dir_sweep_ctrl;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 4;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_dir_sweep_ctrl_if #(.N(N), .DW(DW), .LW(LW)) bus ();

  counter_dir_sweep_ctrl #(.N(N), .DW(DW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural counter_dir with a load port so the bench can preset q.
  logic [N-1:0] cnt_q;
  logic [N-1:0] load_val;
  logic         load_en;
  always @(posedge clk) begin
    if (load_en)     cnt_q <= load_val;
    else if (bus.ce) cnt_q <= bus.dir ? cnt_q + N'(1) : cnt_q - N'(1);
  end
  assign bus.q = cnt_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic load_q(input int v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = N'(v);
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic start_cmd(input int lim, input int dw, input int lp);
    bus.start = 1'b1;
    bus.limit = N'(lim);
    bus.dwell = DW'(dw);
    bus.loops = LW'(lp);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause plen edges once q reaches pq while sweeping up.
  task automatic run_seq(input int q0, input int lim, input int dw, input int lp,
                         input int pmode, input int pq, input int plen, input bit inj,
                         output int steps, output int cycles);
    int  units[$];
    int  qm;
    int  lpe;
    int  exp_state;
    int  p_left;
    bit  p_used;
    bit  last_pause;
    bit  pv;
    bit  exp_ce;
    bit  exp_dir;
    bit  finished;
    load_q(q0);
    qm     = q0;
    lpe    = (lp == 0) ? 1 : lp;
    steps  = 0;
    cycles = 0;
    p_left = 0;
    p_used = 1'b0;
    units.delete();
    if (lim != 0) begin
      repeat (q0) units.push_back(1);
      repeat (lpe) begin
        repeat (lim) units.push_back(2);
        repeat (dw)  units.push_back(3);
        repeat (lim) units.push_back(4);
      end
    end
    last_pause = (pmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    bus.pause  = last_pause;
    start_cmd(lim, dw, lp);
    finished = 1'b0;
    for (int guard = 0; guard < 2000; guard++) begin
      if (units.size() == 0) begin
        finished = 1'b1;
        break;
      end
      exp_state = units[0];
      exp_ce    = (units[0] != 3) && !last_pause;
      exp_dir   = (units[0] == 2);
      n_checks++;
      if (bus.state !== 3'(exp_state) || bus.ce !== exp_ce || bus.dir !== exp_dir ||
          bus.busy !== 1'b1 || bus.done !== 1'b0 || cnt_q !== N'(qm)) begin
        $display("FAIL seq_cycle%0d: got st=%0d ce=%b dir=%b busy=%b done=%b q=%0d, want st=%0d ce=%b dir=%b busy=1 done=0 q=%0d",
                 cycles, bus.state, bus.ce, bus.dir, bus.busy, bus.done, cnt_q,
                 exp_state, exp_ce, exp_dir, qm);
      end else begin
        n_pass++;
      end
      pv = 1'b0;
      if (p_left > 0) begin
        pv = 1'b1;
        p_left--;
      end else if (pmode == 1) begin
        pv = ($urandom_range(0, 3) == 0);
      end else if (pmode == 2 && !p_used && units[0] == 2 && qm + 1 == pq) begin
        pv     = 1'b1;
        p_used = 1'b1;
        p_left = plen - 1;
      end
      bus.pause = pv;
      // Inputs changed mid-sequence (including a second start) must be ignored.
      bus.start = inj && (cycles == 2);
      bus.limit = N'($urandom);
      bus.dwell = DW'($urandom);
      bus.loops = LW'($urandom);
      @(posedge clk);
      if (units[0] == 3) begin
        if (!pv) void'(units.pop_front());
      end else if (exp_ce) begin
        qm = (units[0] == 2) ? qm + 1 : qm - 1;
        steps++;
        void'(units.pop_front());
      end
      last_pause = pv;
      cycles++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    n_checks++;
    if (!finished || bus.state !== 3'd5 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
        bus.ce !== 1'b0 || cnt_q !== N'(qm)) begin
      $display("FAIL seq_done: got st=%0d done=%b busy=%b ce=%b q=%0d fin=%b, want st=5 done=1 busy=0 ce=0 q=%0d fin=1",
               bus.state, bus.done, bus.busy, bus.ce, cnt_q, finished, qm);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL seq_idle: got st=%0d done=%b busy=%b, want st=0 done=0 busy=0",
               bus.state, bus.done, bus.busy);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_q(0);
    n_checks++;
    if (bus.state !== 3'd0 || bus.ce !== 1'b0 || bus.dir !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0) begin
      $display("FAIL reset: got st=%0d ce=%b dir=%b busy=%b done=%b, want all 0",
               bus.state, bus.ce, bus.dir, bus.busy, bus.done);
    end else begin
      n_pass++;
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_sweep();
    int s, c;
    run_seq(0, 5, 3, 2, 0, 0, 0, 1'b0, s, c);
    n_checks++;
    if (s !== 20 || c !== 26) $display("FAIL plan_sweep: got steps=%0d cycles=%0d, want 20/26", s, c);
    else n_pass++;
  endtask

  task automatic test_home();
    int s, c;
    run_seq(3, 4, 0, 1, 0, 0, 0, 1'b0, s, c);
    n_checks++;
    if (s !== 11 || c !== 11) $display("FAIL home: got steps=%0d cycles=%0d, want 11/11", s, c);
    else n_pass++;
  endtask

  task automatic test_pause();
    int s, c;
    run_seq(0, 6, 2, 1, 2, 2, 4, 1'b0, s, c);
    n_checks++;
    if (s !== 12 || c !== 18) $display("FAIL pause: got steps=%0d cycles=%0d, want 12/18", s, c);
    else n_pass++;
  endtask

  task automatic test_abort();
    int s, c;
    bit saw_done;
    load_q(0);
    start_cmd(5, 6, 1);
    saw_done = 1'b0;
    for (int i = 0; i < 30 && bus.state !== 3'd3; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bus.state !== 3'd3) $display("FAIL abort_reach_dwell: got st=%0d, want 3", bus.state);
    else n_pass++;
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.state !== 3'd0 || bus.ce !== 1'b0 || bus.done !== 1'b0 || cnt_q !== N'(5)) begin
      $display("FAIL abort: got st=%0d ce=%b done=%b q=%0d, want st=0 ce=0 done=0 q=5",
               bus.state, bus.ce, bus.done, cnt_q);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    if (bus.done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done pulse=1, want 0");
    else n_pass++;
    run_seq(5, 5, 2, 1, 0, 0, 0, 1'b0, s, c);
    n_checks++;
    if (s !== 15) $display("FAIL abort_rehome: got steps=%0d, want 15", s);
    else n_pass++;
  endtask

  task automatic test_limit_zero();
    int s, c;
    run_seq(3, 0, 2, 2, 0, 0, 0, 1'b0, s, c);
    n_checks++;
    if (s !== 0 || c !== 0) $display("FAIL limit_zero: got steps=%0d cycles=%0d, want 0/0", s, c);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    int s, c;
    run_seq(0, 3, 1, 1, 0, 0, 0, 1'b1, s, c);
    n_checks++;
    if (s !== 6 || c !== 7) $display("FAIL busy_start: got steps=%0d cycles=%0d, want 6/7", s, c);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_q(0);
    start_cmd(5, 1, 2);
    for (int i = 0; i < 40 && bus.state !== 3'd4; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.state !== 3'd4 || bus.ce !== 1'b1) begin
      $display("FAIL reset_mid_reach_down: got st=%0d ce=%b, want st=4 ce=1", bus.state, bus.ce);
    end else begin
      n_pass++;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.state !== 3'd0 || bus.ce !== 1'b0 || bus.busy !== 1'b0 || bus.dir !== 1'b0 ||
        bus.done !== 1'b0) begin
      $display("FAIL reset_mid: got st=%0d ce=%b busy=%b dir=%b done=%b, want all 0",
               bus.state, bus.ce, bus.busy, bus.dir, bus.done);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loops_zero();
    int s0, c0, s1, c1;
    run_seq(1, 4, 2, 0, 0, 0, 0, 1'b0, s0, c0);
    run_seq(1, 4, 2, 1, 0, 0, 0, 1'b0, s1, c1);
    n_checks++;
    if (s0 !== 9 || s0 !== s1 || c0 !== c1) begin
      $display("FAIL loops_zero: got loops0 steps=%0d cycles=%0d loops1 steps=%0d cycles=%0d, want 9/11 both",
               s0, c0, s1, c1);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_random();
    int s, c, q0, lim, dw, lp, lpe, want;
    for (int it = 0; it < 10; it++) begin
      q0   = $urandom_range(0, 7);
      lim  = $urandom_range(0, 7);
      dw   = $urandom_range(0, 3);
      lp   = $urandom_range(0, 3);
      lpe  = (lp == 0) ? 1 : lp;
      want = (lim == 0) ? 0 : q0 + 2 * lim * lpe;
      run_seq(q0, lim, dw, lp, 1, 0, 0, bit'($urandom_range(0, 1)), s, c);
      n_checks++;
      if (s !== want) $display("FAIL random%0d_steps: got %0d, want %0d", it, s, want);
      else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    load_en   = 1'b0;
    load_val  = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.limit = '0;
    bus.dwell = '0;
    bus.loops = '0;
    test_reset();
    test_plan_sweep();
    test_home();
    test_pause();
    test_abort();
    test_limit_zero();
    test_busy_start();
    test_reset_mid();
    test_loops_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
